// File: rtl/bus_unit.sv
// bus_unit: DMG CPU-side bus decode with local HRAM/IF/IE and OAM/external routing.
// Define BUS_UNIT_OAM_DMA_EN to build the OAM DMA engine and its CPU bus lockout.
module bus_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    output logic [7:0]  cpu_d_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    input  logic [7:0]  oam_rdata,
    input  logic [4:0]  irq_req,
    output logic [4:0]  if_o,
    output logic [7:0]  ie_o,
    output logic        dma_busy
);
    logic       is_hram, is_ie, is_if, is_dma_reg, is_oam, is_unusable, is_ext;
    logic       active;
    logic [4:0] if_reg;
    logic [7:0] ie_reg;
    logic [7:0] hram [0:126];

    always_comb begin
        is_hram     = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);
        is_ie       = (cpu_addr == 16'hFFFF);
        is_if       = (cpu_addr == 16'hFF0F);
`ifdef BUS_UNIT_OAM_DMA_EN
        is_dma_reg  = (cpu_addr == 16'hFF46);
`else
        is_dma_reg  = 1'b0;
`endif
        is_oam      = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
        is_unusable = (cpu_addr >= 16'hFEA0) && (cpu_addr <= 16'hFEFF);
        is_ext      = !(is_hram || is_ie || is_if || is_dma_reg || is_oam || is_unusable);
    end

    // A same-cycle interrupt request always survives a CPU write that clears IF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_reg <= 5'd0;
            ie_reg <= 8'd0;
        end else begin
            if_reg <= ((cpu_write && is_if) ? cpu_d_out[4:0] : if_reg) | irq_req;
            if (cpu_write && is_ie)
                ie_reg <= cpu_d_out;
        end
    end

    // HRAM keeps its contents across reset, so it has no reset branch.
    always_ff @(posedge clk) begin
        if (rst && cpu_write && is_hram)
            hram[cpu_addr[6:0]] <= cpu_d_out;
    end

    assign if_o = if_reg;
    assign ie_o = ie_reg;

`ifdef BUS_UNIT_OAM_DMA_EN
    typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_ACTIVE} dma_state_t;

    dma_state_t state, state_next;
    logic [7:0] dma_src, dma_idx, src_eff;
    logic       dma_write;

    assign dma_write = cpu_write && is_dma_reg;
    // Sources above DF mirror down into WRAM echo space.
    assign src_eff   = (dma_src > 8'hDF) ? (dma_src - 8'h20) : dma_src;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= DMA_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DMA_IDLE:   state_next = DMA_IDLE;
            DMA_START:  state_next = DMA_ACTIVE;
            DMA_ACTIVE: if (dma_idx == 8'd159) state_next = DMA_IDLE;
            default:    state_next = DMA_IDLE;
        endcase
        if (dma_write)
            state_next = DMA_START;
    end

    always_comb begin
        active   = (state == DMA_ACTIVE);
        dma_busy = (state != DMA_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_src <= 8'hFF;
            dma_idx <= 8'd0;
        end else if (dma_write) begin
            dma_src <= cpu_d_out;
            dma_idx <= 8'd0;
        end else if (active) begin
            dma_idx <= (dma_idx == 8'd159) ? 8'd0 : dma_idx + 8'd1;
        end
    end
`else
    assign active   = 1'b0;
    assign dma_busy = 1'b0;
`endif

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_d_out;
        mem_we    = cpu_write && is_ext && !active;
        oam_addr  = cpu_addr[7:0];
        oam_wdata = cpu_d_out;
        oam_we    = cpu_write && is_oam && !active;

        if (is_hram)
            cpu_d_in = hram[cpu_addr[6:0]];
        else if (is_ie)
            cpu_d_in = ie_reg;
        else if (is_if)
            cpu_d_in = {3'b111, if_reg};
`ifdef BUS_UNIT_OAM_DMA_EN
        else if (is_dma_reg)
            cpu_d_in = dma_src;
`endif
        else if (active)
            cpu_d_in = 8'hFF;
        else if (is_oam)
            cpu_d_in = oam_rdata;
        else if (is_unusable)
            cpu_d_in = 8'h00;
        else
            cpu_d_in = mem_rdata;

`ifdef BUS_UNIT_OAM_DMA_EN
        if (active) begin
            mem_addr  = {src_eff, dma_idx};
            oam_addr  = dma_idx;
            oam_wdata = mem_rdata;
            oam_we    = 1'b1;
        end
`endif

        // Reset forces the bus quiet regardless of what the core presents.
        if (!rst) begin
            mem_addr = 16'h0000;
            mem_we   = 1'b0;
            oam_we   = 1'b0;
            cpu_d_in = 8'hFF;
        end
    end
endmodule

// File: tb/tb_bus_unit.sv
// tb_bus_unit: randomized scoreboard bench for bus_unit against a memory-map reference model.
// Works with or without BUS_UNIT_OAM_DMA_EN defined.
module tb_bus_unit;
    localparam int K_DIN   = 0;
    localparam int K_MADDR = 1;
    localparam int K_BUSY  = 2;
    localparam int K_IF    = 3;
    localparam int K_IE    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic [7:0]  cpu_d_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic [7:0]  oam_rdata;
    logic [4:0]  irq_req;
    logic [4:0]  if_o;
    logic [7:0]  ie_o;
    logic        dma_busy;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
    } obs_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] maddr;
        bit          chk_maddr;
    } wr_t;

    obs_t  obs_q[$];
    string obs_name_q[$];
    wr_t   oam_q[$];
    wr_t   ext_q[$];

    int checks   = 0;
    int failures = 0;
    int edges    = 0;

    // Reference model of the memory map and DMA timing window
    logic [7:0] hram_m [0:126];
    bit         hram_ok [0:126];
    logic [7:0] oam_m [0:159];
    logic [7:0] oam_mem [0:255];
    logic [7:0] ie_m;
    logic [4:0] if_m;
    logic [7:0] dma_m;
    int         dma_from  = -1000;
    int         dma_until = -1000;

    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_wr;
    logic [4:0]  r_irq;

    always #5 clk = ~clk;

    bus_unit dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out), .cpu_write(cpu_write), .cpu_d_in(cpu_d_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we), .oam_rdata(oam_rdata),
        .irq_req(irq_req), .if_o(if_o), .ie_o(ie_o), .dma_busy(dma_busy)
    );

    function automatic logic [7:0] ext_data(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    assign mem_rdata = ext_data(mem_addr);
    assign oam_rdata = oam_mem[oam_addr];

    always @(posedge clk) begin
        edges++;
        if (oam_we === 1'b1)
            oam_mem[oam_addr] <= oam_wdata;
    end

    function automatic bit is_ext_m(input logic [15:0] a);
        bit other;
        other = (a >= 16'hFE00);
`ifndef BUS_UNIT_OAM_DMA_EN
        if (a >= 16'hFF00 && a < 16'hFF80 && a != 16'hFF0F)
            other = 1'b0;
`else
        if (a >= 16'hFF00 && a < 16'hFF80 && a != 16'hFF0F && a != 16'hFF46)
            other = 1'b0;
`endif
        return !other;
    endfunction

    function automatic bit is_active(input int e);
        return (e > dma_from) && (e <= dma_until);
    endfunction

    function automatic logic [8:0] model_read(input logic [15:0] a, input bit act);
        int i;
        if (a >= 16'hFF80 && a <= 16'hFFFE) begin
            i = int'(a - 16'hFF80);
            return hram_ok[i] ? {1'b1, hram_m[i]} : 9'h000;
        end
        if (a == 16'hFFFF) return {1'b1, ie_m};
        if (a == 16'hFF0F) return {1'b1, 3'b111, if_m};
`ifdef BUS_UNIT_OAM_DMA_EN
        if (a == 16'hFF46) return {1'b1, dma_m};
`endif
        if (act) return 9'h1FF;
        if (a >= 16'hFE00 && a <= 16'hFE9F) return {1'b1, oam_m[int'(a - 16'hFE00)]};
        if (a >= 16'hFEA0 && a <= 16'hFEFF) return 9'h100;
        return {1'b1, ext_data(a)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    task automatic push_obs(input int e, input int kind, input logic [31:0] exp, input string name);
        obs_t o;
        o.cyc  = e;
        o.kind = kind;
        o.exp  = exp;
        obs_q.push_back(o);
        obs_name_q.push_back(name);
    endtask

    task automatic push_wr(input bit to_oam, input int e, input logic [15:0] a, input logic [7:0] d,
                           input logic [15:0] ma, input bit chk);
        wr_t w;
        w.cyc = e; w.addr = a; w.data = d; w.maddr = ma; w.chk_maddr = chk;
        if (to_oam) oam_q.push_back(w);
        else        ext_q.push_back(w);
    endtask

    // One bus cycle: drive inputs, predict this cycle's outputs, then commit at the edge.
    task automatic applyStimulus(input logic r, input logic [15:0] a, input logic [7:0] d,
                                 input logic w, input logic [4:0] irq);
        int          e, idx;
        bit          act;
        logic [8:0]  rd;
        logic [7:0]  eff;
        logic [15:0] da;
        rst = r; cpu_addr = a; cpu_d_out = d; cpu_write = w; irq_req = irq;
        e = edges;
        if (!r) begin
            if_m = 5'd0; ie_m = 8'd0; dma_m = 8'hFF;
            dma_from = -1000; dma_until = -1000;
            push_obs(e, K_DIN, 32'hFF, "reset_d_in");
            push_obs(e, K_MADDR, 32'h0, "reset_mem_addr");
            push_obs(e, K_BUSY, 32'h0, "reset_dma_busy");
            push_obs(e, K_IF, 32'h0, "reset_if");
            push_obs(e, K_IE, 32'h0, "reset_ie");
        end else begin
            act = is_active(e);
            rd  = model_read(a, act);
            if (rd[8]) push_obs(e, K_DIN, {24'h0, rd[7:0]}, "cpu_d_in");
            push_obs(e, K_BUSY, {31'h0, (e >= dma_from && e <= dma_until)}, "dma_busy");
            push_obs(e, K_IF, {27'h0, if_m}, "if_o");
            push_obs(e, K_IE, {24'h0, ie_m}, "ie_o");
            if (is_ext_m(a) && !act) push_obs(e, K_MADDR, {16'h0, a}, "mem_addr");
            if (act) begin
                idx = e - dma_from - 1;
                eff = (dma_m > 8'hDF) ? dma_m - 8'h20 : dma_m;
                da  = {eff, idx[7:0]};
                push_wr(1'b1, e, {8'h0, idx[7:0]}, ext_data(da), da, 1'b1);
                oam_m[idx] = ext_data(da);
            end
            if (w && !act && is_ext_m(a)) push_wr(1'b0, e, a, d, a, 1'b0);
            if (w && !act && a >= 16'hFE00 && a <= 16'hFE9F) begin
                push_wr(1'b1, e, {8'h0, a[7:0]}, d, 16'h0, 1'b0);
                oam_m[int'(a - 16'hFE00)] = d;
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            if (w) begin
                if (a >= 16'hFF80 && a <= 16'hFFFE) begin
                    hram_m[int'(a - 16'hFF80)]  = d;
                    hram_ok[int'(a - 16'hFF80)] = 1'b1;
                end
                if (a == 16'hFFFF) ie_m = d;
`ifdef BUS_UNIT_OAM_DMA_EN
                if (a == 16'hFF46) begin
                    dma_m     = d;
                    dma_from  = e + 1;
                    dma_until = e + 161;
                end
`endif
            end
            if_m = ((w && a == 16'hFF0F) ? d[4:0] : if_m) | irq;
        end
    endtask

    task automatic idle(input int n, input logic [15:0] a);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, a, 8'h00, 1'b0, 5'd0);
    endtask

    // Monitor: pops expectations whenever their cycle arrives or the DUT strobes a write.
    always @(negedge clk) begin
        obs_t  o;
        string nm;
        wr_t   w;
        while (obs_q.size() > 0 && obs_q[0].cyc <= edges) begin
            o  = obs_q.pop_front();
            nm = obs_name_q.pop_front();
            case (o.kind)
                K_DIN:   checkOutput(nm, {24'h0, cpu_d_in}, o.exp);
                K_MADDR: checkOutput(nm, {16'h0, mem_addr}, o.exp);
                K_BUSY:  checkOutput(nm, {31'h0, dma_busy}, o.exp);
                K_IF:    checkOutput(nm, {27'h0, if_o}, o.exp);
                default: checkOutput(nm, {24'h0, ie_o}, o.exp);
            endcase
        end
        while (oam_q.size() > 0 && oam_q[0].cyc < edges) begin
            w = oam_q.pop_front();
            checkOutput("missing_oam_write", w.cyc, edges);
        end
        while (ext_q.size() > 0 && ext_q[0].cyc < edges) begin
            w = ext_q.pop_front();
            checkOutput("missing_mem_write", w.cyc, edges);
        end
        if (oam_we !== 1'b0) begin
            if (oam_q.size() == 0 || oam_q[0].cyc != edges) begin
                checkOutput("unexpected_oam_we", {31'h0, oam_we}, 32'h0);
            end else begin
                w = oam_q.pop_front();
                checkOutput("oam_addr", {24'h0, oam_addr}, {16'h0, w.addr});
                checkOutput("oam_wdata", {24'h0, oam_wdata}, {24'h0, w.data});
                if (w.chk_maddr) checkOutput("dma_mem_addr", {16'h0, mem_addr}, {16'h0, w.maddr});
            end
        end
        if (mem_we !== 1'b0) begin
            if (ext_q.size() == 0 || ext_q[0].cyc != edges) begin
                checkOutput("unexpected_mem_we", {31'h0, mem_we}, 32'h0);
            end else begin
                w = ext_q.pop_front();
                checkOutput("mem_addr_wr", {16'h0, mem_addr}, {16'h0, w.addr});
                checkOutput("mem_wdata", {24'h0, mem_wdata}, {24'h0, w.data});
            end
        end
    end

    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not end, edges=%0d", edges);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) oam_m[i] = 8'h00;
        for (int i = 0; i < 127; i++) hram_ok[i] = 1'b0;
        ie_m = 8'h00; if_m = 5'h00; dma_m = 8'hFF;
        rst = 1'b0; cpu_addr = 16'hFF0F; cpu_d_out = 8'h00; cpu_write = 1'b0; irq_req = 5'd0;
        @(posedge clk);
        #1;

        // Reset values and first reads after release
        applyStimulus(1'b0, 16'hFF0F, 8'h00, 1'b0, 5'd0);
        applyStimulus(1'b0, 16'hC000, 8'h00, 1'b0, 5'd0);
        applyStimulus(1'b1, 16'hFF0F, 8'h00, 1'b0, 5'd0);
        applyStimulus(1'b1, 16'hFFFF, 8'h00, 1'b0, 5'd0);
        applyStimulus(1'b1, 16'hFF46, 8'h00, 1'b0, 5'd0);

        // HRAM at both ends, IE, and the IF clear-vs-request race
        applyStimulus(1'b1, 16'hFF80, 8'h5A, 1'b1, 5'd0);
        applyStimulus(1'b1, 16'hFFFE, 8'hA5, 1'b1, 5'd0);
        applyStimulus(1'b1, 16'hFF80, 8'h00, 1'b0, 5'd0);
        applyStimulus(1'b1, 16'hFFFE, 8'h00, 1'b0, 5'd0);
        applyStimulus(1'b1, 16'hFFFF, 8'h1F, 1'b1, 5'd0);
        applyStimulus(1'b1, 16'hFF0F, 8'h13, 1'b1, 5'd0);
        applyStimulus(1'b1, 16'hFF0F, 8'h00, 1'b1, 5'b00100);
        applyStimulus(1'b1, 16'hFF0F, 8'h00, 1'b0, 5'd0);

        // Region boundaries: OAM, unusable, external
        applyStimulus(1'b1, 16'hFE00, 8'h11, 1'b1, 5'd0);
        applyStimulus(1'b1, 16'hFE9F, 8'h22, 1'b1, 5'd0);
        applyStimulus(1'b1, 16'hFEA0, 8'h33, 1'b1, 5'd0);
        applyStimulus(1'b1, 16'hFEFF, 8'h44, 1'b1, 5'd0);
        applyStimulus(1'b1, 16'hFF7F, 8'h55, 1'b1, 5'd0);
        applyStimulus(1'b1, 16'hFE9F, 8'h00, 1'b0, 5'd0);
        applyStimulus(1'b1, 16'hFEA0, 8'h00, 1'b0, 5'd0);
        applyStimulus(1'b1, 16'hFF7F, 8'h00, 1'b0, 5'd0);

        // Full transfer from C1 with lockout probes mid-flight
        applyStimulus(1'b1, 16'hFF46, 8'hC1, 1'b1, 5'd0);
        applyStimulus(1'b1, 16'hC000, 8'h00, 1'b0, 5'd0);
        for (int i = 0; i < 164; i++) begin
            case (i)
                40:      applyStimulus(1'b1, 16'hC000, 8'h00, 1'b0, 5'd0);
                50:      applyStimulus(1'b1, 16'hC000, 8'h77, 1'b1, 5'd0);
                60:      applyStimulus(1'b1, 16'hFE10, 8'h66, 1'b1, 5'd0);
                70:      applyStimulus(1'b1, 16'hFF81, 8'h99, 1'b1, 5'b00010);
                71:      applyStimulus(1'b1, 16'hFF81, 8'h00, 1'b0, 5'd0);
                default: applyStimulus(1'b1, 16'hFF46, 8'h00, 1'b0, 5'd0);
            endcase
        end

        // Echo-mirrored source, restarted at idx 50
        applyStimulus(1'b1, 16'hFF46, 8'hE0, 1'b1, 5'd0);
        idle(51, 16'hFFFF);
        applyStimulus(1'b1, 16'hFF46, 8'h80, 1'b1, 5'd0);
        idle(165, 16'hFF46);

        // Reset at idx 10 aborts the copy; earlier bytes stay in OAM
        applyStimulus(1'b1, 16'hFF46, 8'hC1, 1'b1, 5'd0);
        idle(11, 16'hFFFF);
        applyStimulus(1'b0, 16'hFFFF, 8'h00, 1'b0, 5'd0);
        applyStimulus(1'b1, 16'hFF46, 8'h00, 1'b0, 5'd0);
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, 16'hFE00 + 16'(i), 8'h00, 1'b0, 5'd0);

        // Randomized traffic over every region
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0:       r_addr = 16'hFF80 + 16'($urandom_range(0, 126));
                1:       r_addr = 16'hFFFF;
                2:       r_addr = 16'hFF0F;
                3:       r_addr = 16'hFF46;
                4:       r_addr = 16'hFE00 + 16'($urandom_range(0, 159));
                5:       r_addr = 16'hFEA0 + 16'($urandom_range(0, 95));
                6:       r_addr = 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
                default: r_addr = 16'($urandom);
            endcase
            r_data = 8'($urandom);
            r_wr   = ($urandom_range(0, 2) == 0);
            if (r_addr == 16'hFF46 && $urandom_range(0, 5) != 0) r_wr = 1'b0;
            r_irq  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            applyStimulus(1'b1, r_addr, r_data, r_wr, r_irq);
        end

        // Let any transfer finish, then read back all of OAM
        idle(170, 16'hFFFF);
        for (int i = 0; i < 160; i++)
            applyStimulus(1'b1, 16'hFE00 + 16'(i), 8'h00, 1'b0, 5'd0);

        @(negedge clk);
        #1;
        checkOutput("pending_observations", obs_q.size(), 0);
        checkOutput("pending_oam_writes", oam_q.size(), 0);
        checkOutput("pending_mem_writes", ext_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_unit.md
# bus_unit

CPU-side memory bus unit sitting directly downstream of the `sm83` core. It consumes the core's `addr`/`d_out`/`write` and returns `d_in` in the same cycle. It decodes the address map, holds HRAM, IF and IE locally, and routes OAM and all other accesses to dedicated ports. It also contains the OAM DMA engine, which copies 160 bytes into OAM while locking the CPU out of the non-HRAM bus.

## Interface
Parameters:
- none; the address map is fixed (Game Boy DMG).

Ports:
- `clk`  in  1  core clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  16  address from core.
- `cpu_d_out`  in  8  write data from core.
- `cpu_write`  in  1  write strobe from core; a write commits at posedge.
- `cpu_d_in`  out  8  read data to core; combinational from `cpu_addr`.
- `mem_addr`  out  16  external bus address (ROM/VRAM/WRAM/cart/IO).
- `mem_wdata`  out  8  external write data.
- `mem_we`  out  1  external write enable.
- `mem_rdata`  in  8  external read data; combinational, same cycle.
- `oam_addr`  out  8  OAM byte index 0..159.
- `oam_wdata`  out  8  OAM write data.
- `oam_we`  out  1  OAM write enable.
- `oam_rdata`  in  8  OAM read data; combinational.
- `irq_req`  in  5  one-cycle interrupt request pulses; bit order VBlank, STAT, Timer, Serial, Joypad (bit 0 first).
- `if_o`  out  5  current IF register.
- `ie_o`  out  8  current IE register.
- `dma_busy`  out  1  DMA in START or ACTIVE state.

## Operation
- **Decode, first match wins:**
  - FF80–FFFE: HRAM, 127×8, internal.
  - FFFF: IE.
  - FF0F: IF. Reads return `{3'b111, IF}`.
  - FF46: DMA source register. Reads return the last value written.
  - FE00–FE9F: OAM port, `oam_addr = cpu_addr[7:0]`.
  - FEA0–FEFF: unusable. Reads return 8'h00; writes are dropped.
  - Everything else: external port. `mem_addr = cpu_addr`, `mem_we = cpu_write`, `cpu_d_in = mem_rdata`.
- **Idle outputs:** `mem_we` and `oam_we` are asserted only for a write to their own region; otherwise both are 0.
- **IF update:** next value is `(cpu write to FF0F ? cpu_d_out[4:0] : IF) | irq_req`. A same-cycle `irq_req` bit always wins over a CPU clear.
- **DMA FSM:** IDLE → START → ACTIVE → IDLE.
  - A write to FF46 with value V latches `src = V`, clears `idx`, and enters START, from any state.
  - START lasts exactly 1 cycle, then goes to ACTIVE.
  - ACTIVE, each cycle:
    - `mem_addr = {src_eff, idx}`, where `src_eff = (V > 8'hDF) ? V - 8'h20 : V`.
    - `oam_addr = idx`, `oam_wdata = mem_rdata`, `oam_we = 1`.
    - `idx` increments.
    - After the cycle with `idx == 159`, the FSM returns to IDLE.
  - `idx` is 8 bits and never wraps past 159.
- **CPU lockout during ACTIVE:**
  - Accesses to HRAM, IE, IF and FF46 behave normally.
  - All other reads return 8'hFF; all other writes are dropped (`mem_we = 0`, no OAM write).
  - During START, the CPU still has the full bus.
- **Restart:** a write to FF46 while ACTIVE restarts the transfer: new `src`, `idx = 0`, START for 1 cycle. The byte written in the current cycle still completes.

## Timing
- **Reset values:**
  - `if_o = 0`, `ie_o = 0`, FF46 register = 8'hFF.
  - DMA state IDLE, `idx = 0`, `dma_busy = 0`.
  - `mem_we = 0`, `oam_we = 0`, `mem_addr = 0`, `cpu_d_in = 8'hFF`.
  - HRAM contents are not reset.
- **Reads:** zero latency, purely combinational.
- **Writes:** take effect at the posedge of the strobe cycle; a read at the same address in the next cycle returns the new value.
- **DMA latency:** FF46 write at edge N; START during cycle N+1; OAM byte 0 written at edge N+2; byte 159 written at edge N+161. `dma_busy` is high from cycle N+1 through N+161 and low in cycle N+162.
- **Mid-transfer reset:** asserting `rst` during ACTIVE aborts immediately: IDLE, `oam_we = 0`. Already-written OAM bytes remain.

## Configuration
- `BUS_UNIT_OAM_DMA_EN` defined: DMA engine and lockout present, as above.
- `BUS_UNIT_OAM_DMA_EN` undefined:
  - No FSM and no FF46 register.
  - FF46 decodes to the external port like any other IO address.
  - `dma_busy` is tied to 0.
  - `oam_we` is driven only by CPU writes.

## Test plan
- Reset → `cpu_d_in` at FF0F = 8'hE0; FFFF reads 8'h00; FF46 reads 8'hFF.
- Write 8'h5A to FF80, then 8'hA5 to FFFE → the reads return 5A and A5; `mem_we` stays 0 throughout.
- `irq_req = 5'b00100` in the same cycle as a CPU write of 0 to FF0F → FF0F reads 8'hE4.
- Write 8'hC1 to FF46 with `mem_rdata = addr[7:0]` → `mem_addr` steps C100..C19F, `oam_wdata` steps 00..9F, `dma_busy` is high for exactly 161 cycles, and a CPU read of C000 during ACTIVE returns FF.
- Write 8'hE0 to FF46 → source addresses C000..C09F. Rewrite FF46 = 8'h80 at idx 50 → one START cycle, then `mem_addr` restarts at 8000.
- Drop `rst` at idx 10 → `dma_busy = 0` and `oam_we = 0` immediately; after release, FF46 reads FF.
